// File: rtl/axis_video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_video_pkg
//  Description : Shared types and constants for the AXI4-Stream video framer:
//                frame-tracking FSM state type, output tlast placement modes
//                and a counter-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_video_pkg;

    // Frame tracking state: waiting for a start-of-frame beat, or inside a frame.
    typedef enum logic [0:0] {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } frame_state_t;

    // Output tlast placement.
    localparam int TLAST_EOF = 0;   // last pixel of the frame
    localparam int TLAST_EOL = 1;   // last pixel of every line

    // Width of a counter holding 0..n-1; at least one bit so n=1 still yields
    // a legal vector.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_skid_buffer
//  Description : Two-entry ready/valid skid buffer. The output register feeds
//                m_* directly; a second (skid) entry absorbs the beat that
//                arrives in the cycle the output stalls. s_ready is a pure
//                register, high iff the skid entry is empty.
//  Ports       : clk, rst_n            clock, async active-low reset
//                s_payload/s_valid     upstream beat
//                s_ready               registered upstream ready
//                m_payload/m_valid     downstream beat (registered)
//                m_ready               downstream ready
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_buffer #(
    parameter int PAYLOAD_WIDTH = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PAYLOAD_WIDTH-1:0] s_payload,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [PAYLOAD_WIDTH-1:0] m_payload,
    output logic                     m_valid,
    input  logic                     m_ready
);

    logic [PAYLOAD_WIDTH-1:0] r_main;
    logic [PAYLOAD_WIDTH-1:0] r_skid;
    logic                     r_main_valid;
    logic                     r_skid_valid;
    logic                     r_s_ready;

    logic w_s_fire;
    logic w_main_free;

    assign w_s_fire    = s_valid && r_s_ready;
    // Output register can take a new beat: empty, or draining this cycle.
    assign w_main_free = !r_main_valid || m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_s_ready    <= 1'b0;
        end else begin
            if (w_main_free) begin
                if (r_skid_valid) begin
                    // Older beat in the skid entry goes first; upstream was
                    // held off this cycle so no new beat can arrive.
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_s_fire) begin
                    r_main       <= s_payload;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
                r_s_ready <= 1'b1;
            end else begin
                if (w_s_fire) begin
                    r_skid       <= s_payload;
                    r_skid_valid <= 1'b1;
                    r_s_ready    <= 1'b0;
                end else begin
                    r_s_ready    <= !r_skid_valid;
                end
            end
        end
    end

    assign s_ready   = r_s_ready;
    assign m_payload = r_main;
    assign m_valid   = r_main_valid;

endmodule
`default_nettype wire

// File: rtl/axis_video_framer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_video_framer
//  Description : AXI4-Stream video framer. Tracks pixel position inside a
//                WIDTH x HEIGHT frame, drops beats seen before start-of-frame,
//                resynchronises on early SOF, regenerates tuser/tlast on the
//                output and reports frame completion and framing errors.
//  Ports       : clk, rst_n                       clock, async active-low reset
//                s_axis_tdata/tvalid/tready/tuser/tlast   video input
//                m_axis_tdata/tvalid/tready/tuser/tlast   video output
//                frame_done                        pulse, frame completed
//                frame_count[15:0]                 completed frames (wraps)
//                err_sof_missing/err_sof_early/err_tlast   error pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_video_framer
    import axis_video_pkg::*;
#(
    parameter int WIDTH      = 2,
    parameter int HEIGHT     = 2,
    parameter int DATA_WIDTH = 24,
    parameter int TLAST_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  err_sof_missing,
    output logic                  err_sof_early,
    output logic                  err_tlast
);

    localparam int CW = cnt_width(WIDTH);
    localparam int RW = cnt_width(HEIGHT);
    localparam int PW = DATA_WIDTH + 2;

    localparam logic [CW-1:0] c_col_last = CW'(WIDTH - 1);
    localparam logic [RW-1:0] c_row_last = RW'(HEIGHT - 1);

    frame_state_t  r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_frame_done;
    logic [15:0]   r_frame_count;
    logic          r_err_sof_missing;
    logic          r_err_sof_early;
    logic          r_err_tlast;

    logic          w_s_ready;
    logic          w_accept;
    logic          w_forward;
    logic          w_early;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_eol;
    logic          w_pix_first;
    logic          w_pix_last;
    logic          w_tlast_gen;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_out_payload;

    assign w_accept  = s_axis_tvalid && w_s_ready;
    // Outside a frame only an SOF beat is forwarded; inside, everything is.
    assign w_forward = (r_state == IN_FRAME) || s_axis_tuser;
    assign w_early   = (r_state == IN_FRAME) && s_axis_tuser &&
                       ((r_col != '0) || (r_row != '0));

    // Effective position of the current beat: any SOF re-anchors to (0,0).
    assign w_col       = s_axis_tuser ? '0 : r_col;
    assign w_row       = s_axis_tuser ? '0 : r_row;
    assign w_eol       = (w_col == c_col_last);
    assign w_pix_first = (w_col == '0) && (w_row == '0);
    assign w_pix_last  = w_eol && (w_row == c_row_last);

    generate
        if (TLAST_MODE == TLAST_EOL) begin : g_tlast_eol
            assign w_tlast_gen = w_eol;
        end else begin : g_tlast_eof
            assign w_tlast_gen = w_pix_last;
        end
    endgenerate

    assign w_in_payload = {w_pix_first, w_tlast_gen, s_axis_tdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= WAIT_SOF;
            r_col             <= '0;
            r_row             <= '0;
            r_frame_done      <= 1'b0;
            r_frame_count     <= 16'd0;
            r_err_sof_missing <= 1'b0;
            r_err_sof_early   <= 1'b0;
            r_err_tlast       <= 1'b0;
        end else begin
            r_frame_done      <= 1'b0;
            r_err_sof_missing <= 1'b0;
            r_err_sof_early   <= 1'b0;
            r_err_tlast       <= 1'b0;
            if (w_accept) begin
                if (!w_forward) begin
                    r_err_sof_missing <= 1'b1;
                end else begin
                    r_err_sof_early <= w_early;
                    r_err_tlast     <= (s_axis_tlast != w_pix_last);
                    if (w_pix_last) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 16'd1;
                        r_state       <= WAIT_SOF;
                        r_col         <= '0;
                        r_row         <= '0;
                    end else begin
                        r_state <= IN_FRAME;
                        if (w_eol) begin
                            r_col <= '0;
                            r_row <= w_row + 1'b1;
                        end else begin
                            r_col <= w_col + 1'b1;
                            r_row <= w_row;
                        end
                    end
                end
            end
        end
    end

    axis_skid_buffer #(
        .PAYLOAD_WIDTH (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_payload (w_in_payload),
        .s_valid   (w_accept && w_forward),
        .s_ready   (w_s_ready),
        .m_payload (w_out_payload),
        .m_valid   (m_axis_tvalid),
        .m_ready   (m_axis_tready)
    );

    assign s_axis_tready   = w_s_ready;
    assign m_axis_tuser    = w_out_payload[PW-1];
    assign m_axis_tlast    = w_out_payload[PW-2];
    assign m_axis_tdata    = w_out_payload[DATA_WIDTH-1:0];
    assign frame_done      = r_frame_done;
    assign frame_count     = r_frame_count;
    assign err_sof_missing = r_err_sof_missing;
    assign err_sof_early   = r_err_sof_early;
    assign err_tlast       = r_err_tlast;

endmodule
`default_nettype wire

// File: tb/tb_axis_video_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_video_framer
//  Description : Self-checking bench for axis_video_framer. Two instances:
//                dut 0 = 2x2 frame, tlast at end of frame; dut 1 = 4x2 frame,
//                tlast at end of line. A pixel-index reference model predicts
//                every output beat, pulse, ready and frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_video_framer;
    import axis_video_pkg::*;

    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    logic [DW-1:0] s_data  [2];
    logic          s_valid [2];
    logic          s_ready [2];
    logic          s_user  [2];
    logic          s_last  [2];
    logic [DW-1:0] m_data  [2];
    logic          m_valid [2];
    logic          m_ready [2];
    logic          m_user  [2];
    logic          m_last  [2];
    logic          done    [2];
    logic          miss    [2];
    logic          early   [2];
    logic          terr    [2];
    logic [15:0]   fcnt    [2];

    axis_video_framer #(.WIDTH(2), .HEIGHT(2), .DATA_WIDTH(DW), .TLAST_MODE(TLAST_EOF)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data[0]), .s_axis_tvalid(s_valid[0]), .s_axis_tready(s_ready[0]),
        .s_axis_tuser(s_user[0]), .s_axis_tlast(s_last[0]),
        .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready[0]),
        .m_axis_tuser(m_user[0]), .m_axis_tlast(m_last[0]),
        .frame_done(done[0]), .frame_count(fcnt[0]),
        .err_sof_missing(miss[0]), .err_sof_early(early[0]), .err_tlast(terr[0]));

    axis_video_framer #(.WIDTH(4), .HEIGHT(2), .DATA_WIDTH(DW), .TLAST_MODE(TLAST_EOL)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_data[1]), .s_axis_tvalid(s_valid[1]), .s_axis_tready(s_ready[1]),
        .s_axis_tuser(s_user[1]), .s_axis_tlast(s_last[1]),
        .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready[1]),
        .m_axis_tuser(m_user[1]), .m_axis_tlast(m_last[1]),
        .frame_done(done[1]), .frame_count(fcnt[1]),
        .err_sof_missing(miss[1]), .err_sof_early(early[1]), .err_tlast(terr[1]));

    // ---------------- counters ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 2 : 4;
    endfunction
    function automatic int mode(input int k);
        return (k == 0) ? TLAST_EOF : TLAST_EOL;
    endfunction

    // ---------------- reference model ----------------
    int          pix [2] = '{-1, -1};   // next pixel index in frame, -1 = waiting for SOF
    int          cnt [2] = '{0, 0};
    logic        acc [2] = '{1'b0, 1'b0};
    logic        e_done [2] = '{1'b0, 1'b0};
    logic        e_miss [2] = '{1'b0, 1'b0};
    logic        e_early[2] = '{1'b0, 1'b0};
    logic        e_terr [2] = '{1'b0, 1'b0};
    logic        rdy_en = 1'b0;
    logic [25:0] fifo [2][64];
    int          wr [2] = '{0, 0};
    int          rd [2] = '{0, 0};

    task automatic model_beat(input int k);
        int n;
        int p;
        n = wid(k) * 2;
        if (pix[k] < 0 && !s_user[k]) begin
            e_miss[k] = 1'b1;
            return;
        end
        if (s_user[k]) begin
            if (pix[k] >= 0) e_early[k] = 1'b1;
            p = 0;
        end else begin
            p = pix[k];
        end
        fifo[k][wr[k] % 64] = {(p == 0),
                               (mode(k) == TLAST_EOF) ? (p == n - 1) : (p % wid(k) == wid(k) - 1),
                               s_data[k]};
        wr[k]++;
        if (s_last[k] != (p == n - 1)) e_terr[k] = 1'b1;
        if (p == n - 1) begin
            e_done[k] = 1'b1;
            cnt[k]    = (cnt[k] + 1) & 32'hFFFF;
            pix[k]    = -1;
        end else begin
            pix[k] = p + 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            rdy_en = 1'b0;
            for (int k = 0; k < 2; k++) begin
                pix[k] = -1; cnt[k] = 0; wr[k] = 0; rd[k] = 0; acc[k] = 1'b0;
                e_done[k] = 1'b0; e_miss[k] = 1'b0; e_early[k] = 1'b0; e_terr[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc[k] = s_valid[k] && s_ready[k];
                e_done[k] = 1'b0; e_miss[k] = 1'b0; e_early[k] = 1'b0; e_terr[k] = 1'b0;
                if (m_valid[k] && m_ready[k] && rd[k] != wr[k]) rd[k]++;
                if (acc[k]) model_beat(k);
            end
            rdy_en = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    logic [25:0] obs [2][16];
    int n_obs   [2] = '{0, 0};
    int n_done  [2] = '{0, 0};
    int n_miss  [2] = '{0, 0};
    int n_early [2] = '{0, 0};
    int n_terr  [2] = '{0, 0};

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                chk("m_valid", k, m_valid[k], wr[k] != rd[k]);
                if (m_valid[k] && wr[k] != rd[k])
                    chk("beat", k, {m_user[k], m_last[k], m_data[k]}, fifo[k][rd[k] % 64]);
                chk("s_ready", k, s_ready[k], rdy_en && (wr[k] - rd[k] < 2));
                chk("pulses", k, {done[k], miss[k], early[k], terr[k]},
                    {e_done[k], e_miss[k], e_early[k], e_terr[k]});
                chk("frame_count", k, fcnt[k], cnt[k]);
                if (m_valid[k] && m_ready[k]) begin
                    obs[k][n_obs[k] % 16] = {m_user[k], m_last[k], m_data[k]};
                    n_obs[k]++;
                end
                n_done[k]  += int'(done[k]);
                n_miss[k]  += int'(miss[k]);
                n_early[k] += int'(early[k]);
                n_terr[k]  += int'(terr[k]);
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    int rmode [2] = '{0, 0};   // 0 always ready, 1 pattern 1,0,0, 2 random
    int ph    [2] = '{0, 0};

    initial forever begin
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            case (rmode[k])
                0:       m_ready[k] = 1'b1;
                1:       begin m_ready[k] = (ph[k] % 3 == 0); ph[k]++; end
                default: m_ready[k] = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input int k, input logic [DW-1:0] d, input logic u, input logic l);
        int t;
        t = 0;
        s_valid[k] = 1'b1; s_data[k] = d; s_user[k] = u; s_last[k] = l;
        do begin tick(); t++; end while (!acc[k] && t < 200);
        if (!acc[k]) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout dut%0d: beat %h not accepted in 200 cycles", k, d);
        end
        s_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wr[0] != rd[0] || wr[1] != rd[1]) && t < 500) begin tick(); t++; end
        if (wr[0] != rd[0] || wr[1] != rd[1]) begin
            n_chk++; n_fail++;
            $display("FAIL drain_timeout: output beats still pending after 500 cycles");
        end
        repeat (2) tick();
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 2; k++) begin
            chk("rst_flags", k, {s_ready[k], m_valid[k], m_user[k], m_last[k],
                                 done[k], miss[k], early[k], terr[k]}, 32'd0);
            chk("rst_tdata", k, m_data[k], 32'd0);
            chk("rst_count", k, fcnt[k], 32'd0);
        end
    endtask

    task automatic send_frame4(input int k, input logic [DW-1:0] base);
        for (int i = 0; i < 4; i++) send(k, base + DW'(i), (i == 0), (i == 3));
    endtask

    task automatic rand_stream(input int k, input int nbeats);
        int n;
        int sp;
        logic u;
        logic l;
        n  = wid(k) * 2;
        sp = 0;
        for (int i = 0; i < nbeats; i++) begin
            u = (sp == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0);
            if (u) sp = 0;
            l = (sp == n - 1) ^ ($urandom_range(0, 15) == 0);
            send(k, DW'($urandom), u, l);
            sp = (sp + 1) % n;
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int k = 0; k < 2; k++) begin
            s_valid[k] = 1'b0; s_data[k] = '0; s_user[k] = 1'b0; s_last[k] = 1'b0;
            m_ready[k] = 1'b1;
        end
        #12;
        check_reset_values();
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 0, s_ready[0], 32'd0);
        tick();
        chk("ready_after_edge", 0, s_ready[0], 32'd1);

        // Plain 2x2 frame, always-ready sink.
        n_obs[0] = 0; n_done[0] = 0;
        send_frame4(0, 24'h000001);
        drain();
        chk("t1_count", 0, fcnt[0], 32'd1);
        chk("t1_done_pulses", 0, n_done[0], 32'd1);
        chk("t1_pix0", 0, obs[0][0], {2'b10, 24'h000001});
        chk("t1_pix1", 0, obs[0][1], {2'b00, 24'h000002});
        chk("t1_pix2", 0, obs[0][2], {2'b00, 24'h000003});
        chk("t1_pix3", 0, obs[0][3], {2'b01, 24'h000004});

        // Same frame with a stalling sink.
        rmode[0] = 1;
        n_obs[0] = 0;
        send_frame4(0, 24'h000001);
        drain();
        chk("t2_nbeats", 0, n_obs[0], 32'd4);
        chk("t2_pix1", 0, obs[0][1], {2'b00, 24'h000002});
        chk("t2_pix3", 0, obs[0][3], {2'b01, 24'h000004});
        rmode[0] = 0;

        // Two beats before SOF are dropped.
        n_obs[0] = 0; n_miss[0] = 0;
        send(0, 24'h0000AA, 1'b0, 1'b0);
        send(0, 24'h0000BB, 1'b0, 1'b0);
        send_frame4(0, 24'h000011);
        drain();
        chk("t3_miss_pulses", 0, n_miss[0], 32'd2);
        chk("t3_first_out", 0, obs[0][0], {2'b10, 24'h000011});
        chk("t3_count", 0, fcnt[0], 32'd3);

        // SOF re-asserted on the third pixel.
        n_obs[0] = 0; n_early[0] = 0;
        send(0, 24'h000001, 1'b1, 1'b0);
        send(0, 24'h000002, 1'b0, 1'b0);
        send(0, 24'h000003, 1'b1, 1'b0);
        send(0, 24'h000004, 1'b0, 1'b0);
        drain();
        chk("t4_early_pulses", 0, n_early[0], 32'd1);
        chk("t4_restart_pix", 0, obs[0][2], {2'b10, 24'h000003});
        chk("t4_count_held", 0, fcnt[0], 32'd3);
        send(0, 24'h000005, 1'b0, 1'b0);
        send(0, 24'h000006, 1'b0, 1'b1);
        drain();
        chk("t4_count_after", 0, fcnt[0], 32'd4);

        // 4x2 frame, per-line tlast, input tlast missing on last pixel.
        n_obs[1] = 0; n_terr[1] = 0;
        for (int i = 0; i < 8; i++) send(1, 24'h000010 + DW'(i), (i == 0), 1'b0);
        drain();
        chk("t5_eol_pix3", 1, obs[1][3], {2'b01, 24'h000013});
        chk("t5_mid_pix5", 1, obs[1][5], {2'b00, 24'h000015});
        chk("t5_eol_pix7", 1, obs[1][7], {2'b01, 24'h000017});
        chk("t5_tlast_err", 1, n_terr[1], 32'd1);
        chk("t5_count", 1, fcnt[1], 32'd1);

        // Reset in the middle of a frame.
        send(0, 24'h000001, 1'b1, 1'b0);
        send(0, 24'h000002, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_values();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_obs[0] = 0;
        send_frame4(0, 24'h000021);
        drain();
        chk("t6_count", 0, fcnt[0], 32'd1);
        chk("t6_pix0", 0, obs[0][0], {2'b10, 24'h000021});
        chk("t6_pix3", 0, obs[0][3], {2'b01, 24'h000024});

        // Randomised traffic on both instances with a random sink.
        rmode[0] = 2; rmode[1] = 2;
        fork
            rand_stream(0, 300);
            rand_stream(1, 300);
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
